// File: rtl/ifetch_queue.sv
// Fetch front end: PC, sequential imem reads, and a QDEPTH-entry instruction queue toward decode.
// Latency: request to head-valid is 2 cycles, or 1 with CH0RE_IFQ_BYPASS_EN defined (empty-queue bypass).
// Backpressure: requests are credit-gated on registered occupancy plus in-flight, so the queue never overflows.
module ifetch_queue #(
    parameter int              PC_W     = 64,
    parameter int              ILEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_,
    output logic                      imem_req_o,
    output logic [PC_W-1:0]           imem_addr_o,
    input  logic [ILEN-1:0]           imem_rdata_i,
    input  logic                      redirect_i,
    input  logic [PC_W-1:0]           redirect_pc_i,
    output logic                      inst_valid_o,
    output logic [ILEN-1:0]           inst_o,
    output logic [PC_W-1:0]           inst_pc_o,
    input  logic                      inst_ready_i,
    output logic [$clog2(QDEPTH):0]   ifq_count_o
);

    localparam int            AW    = $clog2(QDEPTH);
    localparam int            CW    = AW + 1;
    localparam logic [CW:0]   DEPTH = (CW+1)'(QDEPTH);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] inflight_pc_q;
    logic            inflight_q;
    logic [ILEN-1:0] inst_mem [QDEPTH];
    logic [PC_W-1:0] pc_mem   [QDEPTH];
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;

    logic credit;
    logic resp;
    logic q_empty;
    logic q_full;
    logic push;
    logic pop;

    // Credit deliberately ignores inst_ready_i so there is no ready-to-request path.
    assign credit      = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH;
    assign imem_req_o  = rst_ && credit && !redirect_i;
    assign imem_addr_o = pc_q;
    assign resp        = inflight_q && !redirect_i;
    assign q_empty     = (count_q == '0);
    assign q_full      = (count_q == DEPTH[CW-1:0]);
    assign pop         = !q_empty && inst_ready_i;
    assign ifq_count_o = count_q;

`ifdef CH0RE_IFQ_BYPASS_EN
    logic byp;
    assign byp          = q_empty && resp;
    assign inst_valid_o = !q_empty || byp;
    assign inst_o       = !q_empty ? inst_mem[head_q] : (byp ? imem_rdata_i  : '0);
    assign inst_pc_o    = !q_empty ? pc_mem[head_q]   : (byp ? inflight_pc_q : '0);
    // A bypassed response consumed in its arrival cycle never touches storage.
    assign push         = resp && !(byp && inst_ready_i);
`else
    assign inst_valid_o = !q_empty;
    assign inst_o       = q_empty ? '0 : inst_mem[head_q];
    assign inst_pc_o    = q_empty ? '0 : pc_mem[head_q];
    assign push         = resp;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else if (redirect_i) begin
            pc_q       <= {redirect_pc_i[PC_W-1:2], 2'b00};
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            if (imem_req_o) begin
                pc_q          <= pc_q + PC_W'(4);
                inflight_q    <= 1'b1;
                inflight_pc_q <= pc_q;
            end else begin
                inflight_q <= 1'b0;
            end
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= imem_rdata_i;
            pc_mem[tail_q]   <= inflight_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_) !(push && q_full && !pop));

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch front end that sits directly upstream of the five-stage pipeline's decode stage. It holds the program counter, issues sequential reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small queue. It presents them to the pipeline over a valid/ready handshake and flushes on a redirect from the execute stage (branch/jump).

## Interface
- `PC_W`, 64: program-counter width in bits.
- `ILEN`, 32: instruction width in bits.
- `QDEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 0: PC loaded on reset; bits [1:0] must be zero.

- `clk`  in  1  sole clock, rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `imem_req_o`  out  1  read request this cycle.
- `imem_addr_o`  out  PC_W  byte address of request, bits [1:0] always 0.
- `imem_rdata_i`  in  ILEN  read data, valid exactly one cycle after a request.
- `redirect_i`  in  1  flush and restart fetch.
- `redirect_pc_i`  in  PC_W  new fetch PC; bits [1:0] ignored (forced 0).
- `inst_valid_o`  out  1  queue head valid.
- `inst_o`  out  ILEN  head instruction.
- `inst_pc_o`  out  PC_W  head instruction's PC.
- `inst_ready_i`  in  1  consumer accepts head when high with valid.
- `ifq_count_o`  out  $clog2(QDEPTH)+1  registered occupancy.

## Operation
- State: `pc_q`, `inflight_q` (one request outstanding), `inflight_pc_q`, queue RAM + head/tail pointers, `count_q`.
- Credit: `credit = (count_q + inflight_q) < QDEPTH`; uses registered values only, never `inst_ready_i`.
- `imem_req_o = credit && !redirect_i`; `imem_addr_o = pc_q`. On request: `pc_q += 4`, `inflight_q <= 1`, `inflight_pc_q <= pc_q`; otherwise `inflight_q <= 0`.
- Response: if `inflight_q` and not redirect this cycle, `{imem_rdata_i, inflight_pc_q}` pushed at tail.
- Pop: `inst_valid_o && inst_ready_i` advances head.
- Push and pop in same cycle: count unchanged; legal at full and at empty (empty case only with bypass, see Configuration).
- Overflow impossible by credit rule; push when full is a design error (assertion).
- Pointers wrap modulo QDEPTH.
- Redirect (`redirect_i`=1):
  - No request issued this cycle.
  - Response arriving this cycle is discarded.
  - Queue emptied and `inflight_q` cleared at the edge.
  - `pc_q <= {redirect_pc_i[PC_W-1:2], 2'b00}`.
  - A pop handshaking in the redirect cycle still counts as accepted.
  - Redirect on consecutive cycles: last one wins.
- PC arithmetic wraps modulo 2^PC_W without error.

## Timing
- Reset (async assert): `pc_q=RESET_PC`, queue empty, `count_q=0`, `inflight_q=0`.
- Outputs during reset: `inst_valid_o=0`, `imem_req_o=0`, `ifq_count_o=0`, `inst_o=0`, `inst_pc_o=0`.
- Reset release is synchronised by the pipeline top. First request occurs in the first cycle with `rst_` high.
- Request in cycle N: data in cycle N+1, visible at `inst_valid_o` in cycle N+2 (macro off).
- With consumer always ready: one instruction per cycle, no bubbles.
- After redirect in cycle R: request to the new PC in R+1; first valid instruction in R+3 (R+2 with bypass).
- Reset asserted mid-operation: all state cleared immediately; in-flight data ignored.

## Configuration
- `CH0RE_IFQ_BYPASS_EN` defined:
  - When the queue is empty and a response arrives, `inst_valid_o`, `inst_o` and `inst_pc_o` are driven combinationally from `imem_rdata_i`/`inflight_pc_q` in the same cycle.
  - If accepted that cycle, the entry is not written.
  - Fetch-to-decode latency is 1 cycle.
- Macro undefined: head always comes from queue storage; latency 2 cycles; no combinational path from `imem_rdata_i` to outputs.

## Test plan
- Reset, imem word at addr a = a, `inst_ready_i`=1 -> instructions with PCs 0,4,8,… one per cycle, first at cycle 2 (1 with bypass), `inst_o` equals PC.
- Hold `inst_ready_i`=0 for 10 cycles -> exactly 4 requests issued, `ifq_count_o`=4, `imem_req_o`=0 thereafter; release -> PCs 0,4,8,12,16 in order, none lost or duplicated.
- Queue holding 3 entries, pulse redirect to 0x100 -> `inst_valid_o`=0 next cycle; next valid PC 0x100; no stale PCs.
- Redirect to 0x143 -> `imem_addr_o`=0x140 next cycle.
- Redirect in the same cycle as an in-flight response and a pop -> response dropped, pop counted, `ifq_count_o`=0 next cycle.
- Assert `rst_` mid-stream with full queue -> all outputs zero immediately; after release, fetch restarts at `RESET_PC`.
